ctrl_wr_bram: RTL and testbench
===============================

# ctrl_wr_bram

Write-side BRAM controller: drains bytes from the output FIFO, packs each run of 4 bytes little-endian into a 32-bit word, and writes the words to consecutive BRAM word addresses until `data_size` bytes have been stored. It sits between the processing core's output FIFO and the BRAM port that software reads back. It is the mirror of the byte-unpacking read controller on the input side, with identical byte ordering (first byte goes to `wrdata[7:0]`).

## Interface
- `DATA_WIDTH`, 32, BRAM data width; fixed at 4 × `FF_WIDTH`.
- `ADDR_WIDTH`, 32, BRAM byte-address width.
- `NUM_BYTES`, 4, byte-enable width.
- `REG_WIDTH`, 32, width of `data_size`.
- `FF_WIDTH`, 8, FIFO data width.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: level request from the register bank.
- `data_size` in `REG_WIDTH`: byte count; sampled at start acceptance.
- `finish` out 1: transfer complete.
- `bram_clk` out 1: equals `clk`.
- `addr` out `ADDR_WIDTH`: BRAM byte address, word-aligned.
- `wrdata` out `DATA_WIDTH`: packed word.
- `we` out `NUM_BYTES`: byte write enables.
- `ff_empty` in 1: FIFO empty.
- `ff_rden` out 1: FIFO read strobe, single-cycle pulse.
- `ff_rd_data` in `FF_WIDTH`: FIFO data, valid one cycle after `ff_rden`.

## Operation
- States: IDLE, RD_FF, WAIT_FF, CAPTURE, WR_BRAM, FINISH.
- **IDLE:** all outputs 0 and internals cleared.
  - If `start && data_size != 0`, latch `data_size` into `size_reg` and go to RD_FF.
  - `data_size == 0` is ignored: stay in IDLE with `finish` = 0.
- **RD_FF:**
  - If `ff_empty`, hold with `ff_rden` = 0.
  - Otherwise pulse `ff_rden` = 1 and go to WAIT_FF.
- **WAIT_FF:** `ff_rden` = 0, go to CAPTURE.
- **CAPTURE:**
  - `word_reg[lane]` <= `ff_rd_data`; `byte_cnt` += 1; `lane` += 1 (2-bit).
  - Go to WR_BRAM if `lane == 3` or `byte_cnt + 1 == size_reg`; otherwise go to RD_FF.
- **WR_BRAM:** one cycle with `addr = word_idx << 2`, `wrdata = word_reg`, `we` nonzero (see Configuration).
  - Then `word_idx` += 1, `lane` = 0, `word_reg` = 0.
  - Go to FINISH if `byte_cnt == size_reg`, else go to RD_FF.
- **FINISH:** `finish` = 1, held until `start` is sampled 0, then return to IDLE with `finish` = 0.
- Counters are `REG_WIDTH` wide; `word_idx` is `ADDR_WIDTH - 2` wide and wraps silently.
- `start` deassertion mid-transfer is ignored; only reset aborts.
- Reset mid-operation: next cycle in IDLE, all outputs 0, any partial word discarded, no BRAM write.

## Timing
- Reset values: `finish`, `ff_rden`, `addr`, `wrdata`, `we` all 0.
- `addr`, `wrdata` and `we` are registered and change together; `we` is nonzero for exactly one cycle per word.
- Never-empty FIFO throughput: 3 cycles per byte plus 1 cycle per word write.
- `data_size = 4`, `start` sampled at cycle 0:
  - `ff_rden` pulses at cycles 1, 4, 7, 10.
  - `we` = 4'hF at cycle 13.
  - `finish` = 1 at cycle 14.
- `ff_empty` only stalls in RD_FF. No read is issued while `ff_empty` = 1, and the stall length adds directly to latency.

## Configuration
- `CTRL_WR_BRAM_BYTE_MASK_EN` defined: the final partial word is written with `we` set only for the valid lanes.
  - Remainder 1 → 4'b0001, 2 → 4'b0011, 3 → 4'b0111.
  - Full words use 4'hF.
- Not defined: every write uses `we` = 4'hF; unused upper bytes of a partial word are written as 0x00.

## Structure
- Shared package `bram_ctrl_pkg`: state encodings, `BYTES_PER_WORD = 4`, and the `lane_mask(remainder)` function. The package is shared with the read controller.
- Optional sub-module `byte_packer`: a 4-lane shift/pack register with lane counter and clear.
- The FSM stays in the top module.

## Test plan
- **Aligned:** `data_size` = 8, FIFO bytes 0x11..0x88 →
  - addr 0x0 gets 0x44332211 with `we` = F;
  - addr 0x4 gets 0x88776655 with `we` = F;
  - `finish` = 1.
- **Partial:** `data_size` = 5, bytes 0xA1..0xA5 →
  - addr 0x4 gets 0x000000A5;
  - `we` = 4'b0001 with the macro, 4'hF without.
- **Stall:** `ff_empty` held high for 10 cycles before byte 3 of `data_size` = 4 → no `ff_rden` while empty; `we` at cycle 23; data is correct.
- **Zero size:** `data_size` = 0 with `start` = 1 → no `ff_rden`, no `we`, `finish` stays 0.
- **Reset abort:** `rst_n` = 0 after 2 of 4 bytes → outputs 0 next cycle, no write; a restart writes from addr 0x0.
- **Handshake:** `finish` holds while `start` = 1; `start` → 0 clears `finish` next cycle; a second `start` writes from addr 0x0 again.

Source files
------------

// File: rtl/bram_ctrl_pkg.sv
// rtl/bram_ctrl_pkg.sv - state encodings and lane helpers shared by the BRAM read and write controllers
package bram_ctrl_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_FF   = 3'd1,
    S_WAIT_FF = 3'd2,
    S_CAPTURE = 3'd3,
    S_WR_BRAM = 3'd4,
    S_FINISH  = 3'd5
  } state_e;

  // remainder is the valid-lane count modulo 4, so 0 denotes a full word
  function automatic logic [BYTES_PER_WORD-1:0] lane_mask(input logic [1:0] remainder);
    case (remainder)
      2'd1:    lane_mask = 4'b0001;
      2'd2:    lane_mask = 4'b0011;
      2'd3:    lane_mask = 4'b0111;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - 4-lane little-endian byte pack register with lane counter and clear
module byte_packer
  import bram_ctrl_pkg::*;
#(
  parameter int FF_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clr_i,
  input  logic                               load_i,
  input  logic [FF_WIDTH-1:0]                byte_i,
  output logic [1:0]                         lane_o,
  output logic [BYTES_PER_WORD*FF_WIDTH-1:0] word_nxt_o
);

  logic [1:0]                         lane_q, lane_d;
  logic [BYTES_PER_WORD*FF_WIDTH-1:0] word_q, word_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q <= '0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

  // word_nxt_o already carries the incoming byte so the write word can be registered in the same cycle
  always_comb begin
    word_nxt_o = word_q;
    word_nxt_o[int'(lane_q)*FF_WIDTH +: FF_WIDTH] = byte_i;
    lane_d = lane_q;
    word_d = word_q;
    if (clr_i) begin
      lane_d = '0;
      word_d = '0;
    end else if (load_i) begin
      lane_d = lane_q + 2'd1;
      word_d = word_nxt_o;
    end
  end

  assign lane_o = lane_q;

endmodule

// File: rtl/ctrl_wr_bram.sv
// rtl/ctrl_wr_bram.sv - FIFO-to-BRAM write controller packing bytes into 32-bit words
// Optional CTRL_WR_BRAM_BYTE_MASK_EN: final partial word writes only its valid lanes.
module ctrl_wr_bram
  import bram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_BYTES  = 4,
  parameter int REG_WIDTH  = 32,
  parameter int FF_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [REG_WIDTH-1:0]  data_size,
  output logic                  finish,
  output logic                  bram_clk,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wrdata,
  output logic [NUM_BYTES-1:0]  we,
  input  logic                  ff_empty,
  output logic                  ff_rden,
  input  logic [FF_WIDTH-1:0]   ff_rd_data
);

  state_e                state_q, state_d;
  logic [REG_WIDTH-1:0]  size_q, size_d;
  logic [REG_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-3:0] word_idx_q, word_idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d;
  logic [NUM_BYTES-1:0]  we_q, we_d;
  logic                  pack_clr, pack_load, last_byte;
  logic [1:0]            lane;
  logic [DATA_WIDTH-1:0] packed_word;

  byte_packer #(.FF_WIDTH(FF_WIDTH)) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (pack_clr),
    .load_i     (pack_load),
    .byte_i     (ff_rd_data),
    .lane_o     (lane),
    .word_nxt_o (packed_word)
  );

  assign last_byte = (lane == 2'd3) || ((byte_cnt_q + 1'b1) == size_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      size_q     <= '0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      addr_q     <= '0;
      wrdata_q   <= '0;
      we_q       <= '0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      addr_q     <= addr_d;
      wrdata_q   <= wrdata_d;
      we_q       <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start && (data_size != '0)) state_d = S_RD_FF;
      S_RD_FF:   if (!ff_empty) state_d = S_WAIT_FF;
      S_WAIT_FF: state_d = S_CAPTURE;
      S_CAPTURE: state_d = last_byte ? S_WR_BRAM : S_RD_FF;
      S_WR_BRAM: state_d = (byte_cnt_q == size_q) ? S_FINISH : S_RD_FF;
      S_FINISH:  if (!start) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // addr/wrdata/we are loaded on the CAPTURE edge so they are live exactly during WR_BRAM
  always_comb begin
    ff_rden    = 1'b0;
    finish     = 1'b0;
    pack_clr   = 1'b0;
    pack_load  = 1'b0;
    size_d     = size_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    addr_d     = '0;
    wrdata_d   = '0;
    we_d       = '0;
    case (state_q)
      S_IDLE: begin
        pack_clr   = 1'b1;
        byte_cnt_d = '0;
        word_idx_d = '0;
        size_d     = (start && (data_size != '0)) ? data_size : '0;
      end
      S_RD_FF: ff_rden = !ff_empty;
      S_CAPTURE: begin
        pack_load  = 1'b1;
        byte_cnt_d = byte_cnt_q + 1'b1;
        if (last_byte) begin
          addr_d   = {word_idx_q, 2'b00};
          wrdata_d = packed_word;
`ifdef CTRL_WR_BRAM_BYTE_MASK_EN
          we_d     = NUM_BYTES'(lane_mask(lane + 2'd1));
`else
          we_d     = '1;
`endif
        end
      end
      S_WR_BRAM: begin
        pack_clr   = 1'b1;
        word_idx_d = word_idx_q + 1'b1;
      end
      S_FINISH: finish = 1'b1;
      default: ;
    endcase
  end

  assign bram_clk = clk;
  assign addr     = addr_q;
  assign wrdata   = wrdata_q;
  assign we       = we_q;

endmodule

// File: tb/tb_ctrl_wr_bram.sv
// tb/tb_ctrl_wr_bram.sv - scoreboard bench for ctrl_wr_bram with a byte-level reference model
`timescale 1ns/1ps
module tb_ctrl_wr_bram;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] data_size = '0;
  logic        finish, bram_clk, ff_rden, ff_empty;
  logic [31:0] addr, wrdata;
  logic [3:0]  we;
  logic [7:0]  ff_rd_data = '0;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          fifo_cnt = 0;
  int          fin_cyc = -1;
  bit          stall_en = 1'b0;
  bit          rd_pend = 1'b0;
  logic [7:0]  fifo_q[$];
  logic [7:0]  src[$];
  wr_t         exp_q[$];
  int          rden_q[$];
  int          we_cyc_q[$];
  wr_t         mon_e;

  ctrl_wr_bram dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .data_size  (data_size),
    .finish     (finish),
    .bram_clk   (bram_clk),
    .addr       (addr),
    .wrdata     (wrdata),
    .we         (we),
    .ff_empty   (ff_empty),
    .ff_rden    (ff_rden),
    .ff_rd_data (ff_rd_data)
  );

  assign ff_empty = stall_en || (fifo_cnt == 0);

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model: a read strobe seen in one cycle presents the next byte in the following cycle
  initial forever begin
    @(negedge clk);
    rd_pend = ff_rden;
    @(posedge clk);
    #1;
    if (rd_pend && fifo_q.size() > 0) begin
      ff_rd_data = fifo_q.pop_front();
      fifo_cnt   = fifo_q.size();
    end
  end

  initial forever begin
    @(negedge clk);
    if (ff_rden) begin
      rden_q.push_back(cyc);
      chk("rden_while_empty", ff_empty, 0);
    end
    if (finish && fin_cyc < 0) fin_cyc = cyc;
    if (we != 4'h0) begin
      we_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h we %0h, expected no write", addr, wrdata, we);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", addr, mon_e.a);
        chk("wr_data", wrdata, mon_e.d);
        chk("wr_we", we, mon_e.m);
      end
    end
  end

  task automatic fill_rand(input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(8'($urandom));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_finish"}, finish, 0);
    chk({tag, "_rden"}, ff_rden, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_wrdata"}, wrdata, 0);
    chk({tag, "_we"}, we, 0);
  endtask

  task automatic xfer(input int size, input bit timing, input int stall_len, input bit rand_stall);
    int          c, n;
    bit          ok;
    logic [31:0] d;
    logic [3:0]  m;
    for (int i = 0; i < size; i++) fifo_q.push_back(src[i]);
    fifo_cnt = fifo_q.size();
    for (int w = 0; w * 4 < size; w++) begin
      n = (size - w * 4 > 4) ? 4 : size - w * 4;
      d = '0;
      for (int k = 0; k < n; k++) d = d | (32'(src[w * 4 + k]) << (8 * k));
`ifdef CTRL_WR_BRAM_BYTE_MASK_EN
      m = 4'((1 << n) - 1);
`else
      m = 4'hF;
`endif
      exp_q.push_back('{a: 32'(w * 4), d: d, m: m});
    end
    rden_q.delete();
    we_cyc_q.delete();
    fin_cyc   = -1;
    data_size = 32'(size);
    start     = 1'b1;
    c         = cyc;
    for (int i = 0; i < 3000 && !finish; i++) begin
      tick();
      if (rand_stall) stall_en = ($urandom_range(0, 2) == 0);
      else if (stall_len > 0 && cyc - c == 6) stall_en = 1'b1;
      else if (stall_len > 0 && cyc - c == 7 + stall_len) stall_en = 1'b0;
    end
    stall_en = 1'b0;
    @(negedge clk);
    chk("finish_seen", finish, 1);
    if (timing) begin
      chk("rden_count", rden_q.size(), 4);
      if (rden_q.size() == 4) begin
        chk("rden0_cycle", rden_q[0] - c, 1);
        chk("rden1_cycle", rden_q[1] - c, 4);
        chk("rden2_cycle", rden_q[2] - c, 7 + stall_len);
        chk("rden3_cycle", rden_q[3] - c, 10 + stall_len);
      end
      chk("we_cycle", (we_cyc_q.size() > 0) ? we_cyc_q[0] - c : -1, 13 + stall_len);
      chk("finish_cycle", fin_cyc - c, 14 + stall_len);
    end
    chk("writes_left", exp_q.size(), 0);
    exp_q.delete();
    ok = 1'b1;
    repeat (3) begin
      tick();
      if (!finish) ok = 1'b0;
    end
    chk("finish_hold", ok, 1);
    start = 1'b0;
    tick();
    chk("finish_clear", finish, 0);
    fifo_q.delete();
    fifo_cnt = 0;
  endtask

  initial begin
    int n;
    repeat (3) tick();
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    src = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    xfer(8, 1'b0, 0, 1'b0);

    fill_rand(4);
    xfer(4, 1'b1, 0, 1'b0);

    src = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    xfer(5, 1'b0, 0, 1'b0);

    fill_rand(4);
    xfer(4, 1'b1, 10, 1'b0);

    rden_q.delete();
    we_cyc_q.delete();
    fin_cyc   = -1;
    data_size = '0;
    start     = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    chk("zero_rden", rden_q.size(), 0);
    chk("zero_we", we_cyc_q.size(), 0);
    chk("zero_finish", fin_cyc, -1);
    start = 1'b0;
    tick();

    // abort after two bytes have been captured
    fill_rand(4);
    for (int i = 0; i < 4; i++) fifo_q.push_back(src[i]);
    fifo_cnt = fifo_q.size();
    we_cyc_q.delete();
    data_size = 32'd4;
    start     = 1'b1;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    chk_outputs_zero("abort");
    rst_n = 1'b1;
    start = 1'b0;
    fifo_q.delete();
    fifo_cnt = 0;
    repeat (4) tick();
    chk("abort_no_write", we_cyc_q.size(), 0);

    fill_rand(4);
    xfer(4, 1'b1, 0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 13);
      fill_rand(n);
      xfer(n, 1'b0, 0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
